// File: rtl/sprite_renderer_if.sv
// Raster-in / video-out bundle between the VGA timing generator and the sprite renderer.
// The master drives the raster position and syncs; the slave returns the coloured pixel stream.
interface sprite_renderer_if;
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic        display_on;
  logic        hsync_in;
  logic        vsync_in;
  logic        hsync_out;
  logic        vsync_out;
  logic [11:0] rgb;

  modport master (
    output hpos, vpos, display_on, hsync_in, vsync_in,
    input  hsync_out, vsync_out, rgb
  );

  modport slave (
    input  hpos, vpos, display_on, hsync_in, vsync_in,
    output hsync_out, vsync_out, rgb
  );
endinterface

// File: rtl/sprite_renderer.sv
// Button-driven square sprite over a solid background, two-stage pixel pipeline with aligned syncs.
// Optional macro SPRITE_BORDER_EN adds a 4-pixel white frame and pulls the clamp limits inward.
module sprite_renderer #(
  parameter int unsigned H_DISPLAY    = 640,
  parameter int unsigned V_DISPLAY    = 480,
  parameter int unsigned SIZE         = 32,
  parameter int unsigned STEP         = 4,
  parameter int unsigned START_X      = 304,
  parameter int unsigned START_Y      = 224,
  parameter logic [11:0] SPRITE_COLOR = 12'hF00,
  parameter logic [11:0] BG_COLOR     = 12'h00F
) (
  input  logic              clk,
  input  logic              reset,
  sprite_renderer_if.slave  vga,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_left,
  input  logic              btn_right,
  output logic [9:0]        sprite_x,
  output logic [9:0]        sprite_y
);

`ifdef SPRITE_BORDER_EN
  localparam int unsigned MARGIN = 4;
`else
  localparam int unsigned MARGIN = 0;
`endif
  localparam logic signed [10:0] X_MIN  = 11'(MARGIN);
  localparam logic signed [10:0] Y_MIN  = 11'(MARGIN);
  localparam logic signed [10:0] X_MAX  = 11'(H_DISPLAY - SIZE - MARGIN);
  localparam logic signed [10:0] Y_MAX  = 11'(V_DISPLAY - SIZE - MARGIN);
  localparam logic signed [10:0] STEP_S = 11'(STEP);

  typedef enum logic [1:0] {IDLE, CALC, CLAMP} state_t;

  state_t             state_q, state_d;
  logic [3:0]         btn_sync1_q, btn_sync1_d;  // {up, down, left, right}
  logic [3:0]         btn_sync2_q, btn_sync2_d;
  logic signed [10:0] nx_q, nx_d, ny_q, ny_d;
  logic [9:0]         sprite_x_q, sprite_x_d, sprite_y_q, sprite_y_d;
  logic               hit_q, hit_d, visible_q, visible_d;
  logic               border_q, border_d;
  logic [11:0]        rgb_q, rgb_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d;

  logic               frame_tick;
  logic signed [10:0] dx, dy;
  logic [10:0]        h11, v11, x11, y11;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    btn_sync1_d = {btn_up, btn_down, btn_left, btn_right};
    btn_sync2_d = btn_sync1_q;
    frame_tick  = (vga.hpos == 10'd0) && (vga.vpos == 10'(V_DISPLAY));

    // Opposing buttons pressed together leave the delta at zero.
    dx = '0;
    dy = '0;
    case (btn_sync2_q[1:0])
      2'b01:   dx = STEP_S;
      2'b10:   dx = -STEP_S;
      default: dx = '0;
    endcase
    case (btn_sync2_q[3:2])
      2'b01:   dy = STEP_S;
      2'b10:   dy = -STEP_S;
      default: dy = '0;
    endcase

    state_d    = state_q;
    nx_d       = nx_q;
    ny_d       = ny_q;
    sprite_x_d = sprite_x_q;
    sprite_y_d = sprite_y_q;
    case (state_q)
      IDLE: if (frame_tick) state_d = CALC;
      CALC: begin
        nx_d    = $signed({1'b0, sprite_x_q}) + dx;
        ny_d    = $signed({1'b0, sprite_y_q}) + dy;
        state_d = CLAMP;
      end
      CLAMP: begin
        if (nx_q < X_MIN)      sprite_x_d = X_MIN[9:0];
        else if (nx_q > X_MAX) sprite_x_d = X_MAX[9:0];
        else                   sprite_x_d = nx_q[9:0];
        if (ny_q < Y_MIN)      sprite_y_d = Y_MIN[9:0];
        else if (ny_q > Y_MAX) sprite_y_d = Y_MAX[9:0];
        else                   sprite_y_d = ny_q[9:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // 11-bit compares so x+SIZE near the right edge cannot wrap.
    h11       = {1'b0, vga.hpos};
    v11       = {1'b0, vga.vpos};
    x11       = {1'b0, sprite_x_q};
    y11       = {1'b0, sprite_y_q};
    visible_d = vga.display_on;
    hit_d     = vga.display_on
              && (h11 >= x11) && (h11 < x11 + 11'(SIZE))
              && (v11 >= y11) && (v11 < y11 + 11'(SIZE));
`ifdef SPRITE_BORDER_EN
    border_d  = vga.display_on
              && ((vga.hpos < 10'd4) || (vga.hpos >= 10'(H_DISPLAY - 4))
               || (vga.vpos < 10'd4) || (vga.vpos >= 10'(V_DISPLAY - 4)));
`else
    border_d  = 1'b0;
`endif

    if (!visible_q)    rgb_d = 12'h000;
    else if (hit_q)    rgb_d = SPRITE_COLOR;
    else if (border_q) rgb_d = 12'hFFF;
    else               rgb_d = BG_COLOR;

    hsync_d = vga.hsync_in;
    vsync_d = vga.vsync_in;
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      btn_sync1_q <= '0;
      btn_sync2_q <= '0;
      nx_q        <= '0;
      ny_q        <= '0;
      sprite_x_q  <= 10'(START_X);
      sprite_y_q  <= 10'(START_Y);
      hit_q       <= 1'b0;
      visible_q   <= 1'b0;
      border_q    <= 1'b0;
      rgb_q       <= 12'h000;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      btn_sync1_q <= btn_sync1_d;
      btn_sync2_q <= btn_sync2_d;
      nx_q        <= nx_d;
      ny_q        <= ny_d;
      sprite_x_q  <= sprite_x_d;
      sprite_y_q  <= sprite_y_d;
      hit_q       <= hit_d;
      visible_q   <= visible_d;
      border_q    <= border_d;
      rgb_q       <= rgb_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
    end
  end

  assign sprite_x      = sprite_x_q;
  assign sprite_y      = sprite_y_q;
  assign vga.rgb       = rgb_q;
  assign vga.hsync_out = hsync_q;
  assign vga.vsync_out = vsync_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Self-checking bench for sprite_renderer: pixel vector table with a latency scoreboard,
// plus frame-by-frame motion sequences compared against a small position model.
module tb_sprite_renderer;

`ifdef SPRITE_BORDER_EN
  localparam logic [11:0] EDGE_C = 12'hFFF;
  localparam int          X_LO = 4, X_HI = 604, Y_LO = 4, Y_HI = 444;
`else
  localparam logic [11:0] EDGE_C = 12'h00F;
  localparam int          X_LO = 0, X_HI = 608, Y_LO = 0, Y_HI = 448;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic [9:0] sprite_x, sprite_y;

  always #5 clk = ~clk;

  sprite_renderer_if vif ();

  sprite_renderer dut (
    .clk       (clk),
    .reset     (reset),
    .vga       (vif),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .sprite_x  (sprite_x),
    .sprite_y  (sprite_y)
  );

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } vec_t;

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    int          idx;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   ex, ey;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic set_pos(input int h, input int v);
    vif.hpos       = 10'(h);
    vif.vpos       = 10'(v);
    vif.display_on = (h < 640) && (v < 480);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_step(input int u, input int d, input int l, input int r);
    ex = ex + 4 * (r - l);
    ey = ey + 4 * (d - u);
    if (ex < X_LO) ex = X_LO;
    if (ex > X_HI) ex = X_HI;
    if (ey < Y_LO) ey = Y_LO;
    if (ey > Y_HI) ey = Y_HI;
  endfunction

  task automatic set_btn(input int u, input int d, input int l, input int r);
    btn_up    = (u != 0);
    btn_down  = (d != 0);
    btn_left  = (l != 0);
    btn_right = (r != 0);
    set_pos(10, 481);
    repeat (3) step();
  endtask

  // Tick cycle, then CALC, CLAMP, and one settled cycle; returns at posedge+1.
  task automatic tick_frame();
    set_pos(0, 480);
    step();
    set_pos(1, 480);
    step();
    set_pos(2, 480);
    step();
    set_pos(3, 480);
    step();
  endtask

  task automatic run_frames(input string name, input int n,
                            input int u, input int d, input int l, input int r);
    set_btn(u, d, l, r);
    for (int f = 0; f < n; f++) begin
      tick_frame();
      model_step(u, d, l, r);
      check($sformatf("%s_x_f%0d", name, f), 32'(sprite_x), 32'(ex));
      check($sformatf("%s_y_f%0d", name, f), 32'(sprite_y), 32'(ey));
    end
  endtask

  task automatic do_reset();
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    vif.hsync_in = 1'b0;
    vif.vsync_in = 1'b0;
    set_pos(700, 500);
    reset = 1'b1;
    #1;
    check("rst_rgb", 32'(vif.rgb), 32'h0);
    check("rst_hsync", 32'(vif.hsync_out), 32'h1);
    check("rst_vsync", 32'(vif.vsync_out), 32'h1);
    check("rst_x", 32'(sprite_x), 32'd304);
    check("rst_y", 32'(sprite_y), 32'd224);
    repeat (3) step();
    reset = 1'b0;
    vif.hsync_in = 1'b1;
    vif.vsync_in = 1'b1;
    step();
    ex = 304;
    ey = 224;
  endtask

  task automatic compare_front();
    exp_t e;
    e = sb.pop_front();
    check($sformatf("pix%0d_rgb", e.idx), 32'(vif.rgb), 32'(e.rgb));
    check($sformatf("pix%0d_hsync", e.idx), 32'(vif.hsync_out), 32'(e.hs));
    check($sformatf("pix%0d_vsync", e.idx), 32'(vif.vsync_out), 32'(e.vs));
  endtask

  initial begin
    vecs[0]  = '{10'd320, 10'd240, 1'b1, 1'b1, 12'hF00};
    vecs[1]  = '{10'd0,   10'd0,   1'b0, 1'b1, EDGE_C};
    vecs[2]  = '{10'd700, 10'd10,  1'b1, 1'b0, 12'h000};
    vecs[3]  = '{10'd303, 10'd240, 1'b0, 1'b0, 12'h00F};
    vecs[4]  = '{10'd304, 10'd224, 1'b1, 1'b1, 12'hF00};
    vecs[5]  = '{10'd335, 10'd255, 1'b0, 1'b1, 12'hF00};
    vecs[6]  = '{10'd336, 10'd240, 1'b1, 1'b0, 12'h00F};
    vecs[7]  = '{10'd320, 10'd223, 1'b1, 1'b1, 12'h00F};
    vecs[8]  = '{10'd320, 10'd256, 1'b0, 1'b0, 12'h00F};
    vecs[9]  = '{10'd639, 10'd479, 1'b1, 1'b1, EDGE_C};
    vecs[10] = '{10'd640, 10'd0,   1'b0, 1'b1, 12'h000};
    vecs[11] = '{10'd100, 10'd500, 1'b1, 1'b0, 12'h000};

    do_reset();

    // One quiet frame, then the pixel table with syncs lagging hpos by one cycle.
    run_frames("idle", 1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      set_pos(int'(vecs[i].h), int'(vecs[i].v));
      if (i > 0) begin
        vif.hsync_in = vecs[i-1].hs;
        vif.vsync_in = vecs[i-1].vs;
      end
      sb.push_back('{vecs[i].rgb, vecs[i].hs, vecs[i].vs, i});
      step();
      if (sb.size() == 2) compare_front();
    end
    vif.hsync_in = vecs[11].hs;
    vif.vsync_in = vecs[11].vs;
    step();
    compare_front();
    vif.hsync_in = 1'b1;
    vif.vsync_in = 1'b1;

    // Right held: nothing moves during the visible area, update lands 3 cycles after the tick.
    set_btn(0, 0, 0, 1);
    for (int c = 0; c < 40; c++) begin
      set_pos(200 + c, 100);
      step();
    end
    check("vis_hold_x", 32'(sprite_x), 32'd304);
    set_pos(0, 480);
    step();
    check("tick_p1_x", 32'(sprite_x), 32'd304);
    set_pos(1, 480);
    step();
    check("tick_p2_x", 32'(sprite_x), 32'd304);
    set_pos(2, 480);
    step();
    check("tick_p3_x", 32'(sprite_x), 32'd308);
    set_pos(3, 480);
    step();
    model_step(0, 0, 0, 1);
    run_frames("right", 9, 0, 0, 0, 1);
    check("right10_x", 32'(sprite_x), 32'd344);

    do_reset();
    run_frames("left", 100, 0, 0, 1, 0);
    check("left_pin_x", 32'(sprite_x), 32'(X_LO));

    do_reset();
    run_frames("lrdown", 5, 0, 1, 1, 1);
    check("lrdown_x", 32'(sprite_x), 32'd304);
    check("lrdown_y", 32'(sprite_y), 32'd244);

    do_reset();
    run_frames("down", 80, 0, 1, 0, 0);
    check("down_pin_y", 32'(sprite_y), 32'(Y_HI));

    // Reset asserted while the FSM sits in CALC.
    do_reset();
    run_frames("pre", 3, 0, 0, 0, 1);
    check("pre_x", 32'(sprite_x), 32'd316);
    vif.hsync_in = 1'b0;
    vif.vsync_in = 1'b0;
    set_pos(0, 480);
    step();
    check("calc_hsync_low", 32'(vif.hsync_out), 32'h0);
    reset = 1'b1;
    #1;
    check("midrst_x", 32'(sprite_x), 32'd304);
    check("midrst_y", 32'(sprite_y), 32'd224);
    check("midrst_rgb", 32'(vif.rgb), 32'h0);
    check("midrst_hsync", 32'(vif.hsync_out), 32'h1);
    check("midrst_vsync", 32'(vif.vsync_out), 32'h1);
    set_pos(10, 481);
    repeat (3) step();
    reset = 1'b0;
    vif.hsync_in = 1'b1;
    vif.vsync_in = 1'b1;
    step();
    ex = 304;
    ey = 224;
    run_frames("post", 1, 0, 0, 0, 1);
    check("post_x", 32'(sprite_x), 32'd308);
    check("post_y", 32'(sprite_y), 32'd224);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_renderer.md
# sprite_renderer

Pixel-colour stage directly downstream of the VGA timing generator. Consumes the raster position (`hpos`, `vpos`), `display_on` and the registered `hsync`/`vsync`, and renders one button-controlled square sprite over a solid background. Emits 12-bit RGB plus re-timed sync signals to the board's VGA pins. Sprite position updates once per frame, only during vertical blanking, so the picture never tears.

## Interface
- `H_DISPLAY`, 640, visible width in pixels
- `V_DISPLAY`, 480, visible height in lines
- `SIZE`, 32, sprite edge length in pixels
- `STEP`, 4, pixels moved per frame per pressed direction
- `START_X`, 304, sprite left edge after reset
- `START_Y`, 224, sprite top edge after reset
- `SPRITE_COLOR`, 12'hF00, sprite RGB (4:4:4)
- `BG_COLOR`, 12'h00F, background RGB inside the visible area
- `clk  in  1  pixel clock (25 MHz)`
- `reset  in  1  asynchronous, active-high`
- `hpos  in  10  horizontal raster position`
- `vpos  in  10  vertical raster position`
- `display_on  in  1  high when hpos<640 and vpos<480`
- `hsync_in  in  1  active-low hsync; lags hpos by 1 cycle`
- `vsync_in  in  1  active-low vsync; lags vpos by 1 cycle`
- `btn_up, btn_down, btn_left, btn_right  in  1 each  asynchronous push-buttons, active-high`
- `hsync_out  out  1  hsync_in delayed 1 cycle`
- `vsync_out  out  1  vsync_in delayed 1 cycle`
- `rgb  out  12  pixel colour {R[3:0],G[3:0],B[3:0]}`
- `sprite_x  out  10  current sprite left edge`
- `sprite_y  out  10  current sprite top edge`

## Operation
- Buttons: each passes through a 2-flop synchronizer. Only synchronized values are used.
- Frame tick: one-cycle pulse when `hpos==0 && vpos==V_DISPLAY`. This is the first blanking line, one pulse per frame.
- Motion FSM states: IDLE, CALC, CLAMP.
  - IDLE→CALC on frame tick.
  - CALC: compute signed 11-bit `nx = x + STEP*(right-left)` and `ny = y + STEP*(down-up)`. Opposing buttons pressed together cancel.
  - CALC→CLAMP unconditionally.
  - CLAMP: clamp `nx` to [0, H_DISPLAY-SIZE] and `ny` to [0, V_DISPLAY-SIZE]. Negative values become 0. Load `sprite_x`/`sprite_y`.
  - CLAMP→IDLE unconditionally.
- Hit test (stage 1, registered): `hit = display_on && hpos∈[x, x+SIZE-1] && vpos∈[y, y+SIZE-1]`. Compares are done at 11 bits so no wrap occurs.
- Colour (stage 2, registered):
  - Outside the visible area, `rgb` is 0.
  - Otherwise `rgb` is SPRITE_COLOR when hit, else BG_COLOR (border per Configuration).
- Sync: `hsync_out`/`vsync_out` are registered copies of `hsync_in`/`vsync_in`.

## Timing
- Reset values:
  - `rgb=0`
  - `hsync_out=1`, `vsync_out=1`
  - `sprite_x=START_X`, `sprite_y=START_Y`
  - FSM=IDLE
  - synchronizers, hit and visible pipeline flops = 0
- `rgb` latency: 2 cycles from `hpos`/`vpos`. Sync latency: 1 cycle from `hsync_in`/`vsync_in`, i.e. 2 cycles from `hpos`. `rgb` and the syncs are therefore aligned.
- Button-to-motion: a press must be stable 2 cycles before the CALC cycle to count.
- Position update: `sprite_x`/`sprite_y` change exactly 3 cycles after the frame-tick cycle (tick→CALC→CLAMP→registered). This is always inside vertical blank.
- Frame tick while not in IDLE cannot occur (ticks are 420000 cycles apart). Ignore it if it does.
- Reset mid-frame or mid-FSM: return immediately to reset values. The next frame tick resumes normal motion.
- At a clamp boundary, held buttons keep the position pinned with no overshoot and no wrap.

## Configuration
- `SPRITE_BORDER_EN` defined: a 4-pixel white (12'hFFF) frame is drawn at the visible edges (hpos<4, hpos≥636, vpos<4, vpos≥476).
  - Priority: sprite > border > background.
  - Clamp limits shrink to [4, H_DISPLAY-SIZE-4] and [4, V_DISPLAY-SIZE-4].
- `SPRITE_BORDER_EN` undefined: no border logic; limits as in Operation.

## Test plan
- Reset released, no buttons, one frame → `sprite_x=304`, `sprite_y=224`; pixel (320,240) gives `rgb=12'hF00` and pixel (0,0) gives 12'h00F, both 2 cycles after `hpos`; `rgb=0` at hpos=700.
- `btn_right` held 10 frames → `sprite_x=344`. Each change occurs 3 cycles after `hpos=0, vpos=480`. Nothing changes while `vpos<480`.
- `btn_left` held 100 frames from reset → `sprite_x` reaches 0 and stays 0. With `SPRITE_BORDER_EN` it stops at 4.
- `btn_left` and `btn_right` held together, with `btn_down` held, 5 frames → `sprite_x=304`, `sprite_y=244`.
- `btn_down` held 80 frames → `sprite_y=448` (480-32), pinned thereafter.
- Assert `reset` mid-frame during CALC → outputs return to reset values in the same cycle; the next frame tick moves the sprite normally from 304,224.
